// File: rtl/midi_pkg.sv
// Shared constants, enumerations and helpers for the MIDI channel-voice parser.
package midi_pkg;

    // High nibbles of channel-voice status bytes that the decoder needs to tell apart
    localparam logic [3:0] NIB_NOTE_OFF   = 4'h8;
    localparam logic [3:0] NIB_PROG       = 4'hC;
    localparam logic [3:0] NIB_CH_PRESS   = 4'hD;
    localparam logic [3:0] NIB_PITCH_BEND = 4'hE;

    // System bytes with special handling
    localparam logic [7:0] BYTE_SYSEX    = 8'hF0;
    localparam logic [7:0] BYTE_EOX      = 8'hF7;
    localparam logic [7:0] BYTE_RT_FIRST = 8'hF8;
    localparam logic [7:0] BYTE_RESET    = 8'hFF;

    // Event type reported on evt_type; equals status bits [6:4] of the message
    typedef enum logic [2:0] {
        EVT_NOTE_OFF   = 3'd0,
        EVT_NOTE_ON    = 3'd1,
        EVT_POLY_AT    = 3'd2,
        EVT_CC         = 3'd3,
        EVT_PROG       = 3'd4,
        EVT_CH_PRESS   = 3'd5,
        EVT_PITCH_BEND = 3'd6
    } evt_type_t;

    // Parser FSM states, visible on the debug state port
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_D1 = 3'd1,
        ST_WAIT_D2 = 3'd2,
        ST_SYSEX   = 3'd3,
        ST_SKIP    = 3'd4
    } parser_state_t;

    // Number of data bytes that follow a channel status, from its high nibble
    function automatic logic [1:0] msg_len(input logic [3:0] status_hi);
        return (status_hi == NIB_PROG || status_hi == NIB_CH_PRESS) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: turns UART bytes into channel-voice events with
// running status, real-time passthrough, SysEx skipping and system reset.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic [15:0] CH_MASK_DEFAULT = 16'h0001,
    parameter bit          RUNNING_STATUS  = 1'b1,
    parameter bit          ZERO_VEL_IS_OFF = 1'b1,
    parameter bit          RESET_ON_FF     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [7:0]  data,
    input  logic        dv,
    input  logic        ch_mask_wr,
    input  logic [15:0] ch_mask_in,
    output logic        evt_valid,
    output logic [2:0]  evt_type,
    output logic [3:0]  evt_ch,
    output logic [6:0]  evt_d1,
    output logic [6:0]  evt_d2,
    output logic        rt_valid,
    output logic [7:0]  rt_byte,
    output logic        sys_reset,
    output logic [2:0]  state
);

    parser_state_t state_q, state_d;
    evt_type_t     kind_q, kind_d;        // event kind of the held status
    logic [3:0]    chan_q, chan_d;        // channel of the held status
    logic          len2_q, len2_d;        // held status carries two data bytes
    logic [6:0]    d1_q, d1_d;            // first data byte while in WAIT_D2
    logic [15:0]   mask_q, mask_d;
    logic          evt_valid_q, evt_valid_d;
    evt_type_t     evt_type_q, evt_type_d;
    logic [3:0]    evt_ch_q, evt_ch_d;
    logic [6:0]    evt_d1_q, evt_d1_d;
    logic [6:0]    evt_d2_q, evt_d2_d;
    logic          rt_valid_q, rt_valid_d;
    logic [7:0]    rt_byte_q, rt_byte_d;
    logic          sys_reset_q, sys_reset_d;

    logic          emit;
    logic [6:0]    emit_d1;
    logic [6:0]    emit_d2;

    // Next-state decode: classify the accepted byte and build any event
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        chan_d      = chan_q;
        len2_d      = len2_q;
        d1_d        = d1_q;
        mask_d      = mask_q;
        evt_valid_d = 1'b0;
        evt_type_d  = evt_type_q;
        evt_ch_d    = evt_ch_q;
        evt_d1_d    = evt_d1_q;
        evt_d2_d    = evt_d2_q;
        rt_valid_d  = 1'b0;
        rt_byte_d   = rt_byte_q;
        sys_reset_d = 1'b0;
        emit        = 1'b0;
        emit_d1     = '0;
        emit_d2     = '0;

        // An out-of-range encoding falls back to IDLE
        case (state_q)
            ST_IDLE, ST_WAIT_D1, ST_WAIT_D2, ST_SYSEX, ST_SKIP: ;
            default: state_d = ST_IDLE;
        endcase

        // The mask register is used below before this update, so a status
        // byte in the same cycle as a write is judged by the old mask
        if (ce && ch_mask_wr) begin
            mask_d = ch_mask_in;
        end

        if (ce && dv) begin
            if (data >= BYTE_RT_FIRST) begin
                if (data == BYTE_RESET && RESET_ON_FF) begin
                    state_d     = ST_IDLE;
                    kind_d      = EVT_NOTE_OFF;
                    chan_d      = '0;
                    len2_d      = 1'b0;
                    d1_d        = '0;
                    sys_reset_d = 1'b1;
                end else begin
                    rt_valid_d = 1'b1;
                    rt_byte_d  = data;
                end
            end else if (data >= BYTE_SYSEX && data <= BYTE_EOX) begin
                state_d = (data == BYTE_SYSEX) ? ST_SYSEX : ST_SKIP;
                kind_d  = EVT_NOTE_OFF;
                chan_d  = '0;
                len2_d  = 1'b0;
                d1_d    = '0;
            end else if (data[7:4] >= NIB_NOTE_OFF && data[7:4] <= NIB_PITCH_BEND) begin
                kind_d  = evt_type_t'(data[6:4]);
                chan_d  = data[3:0];
                len2_d  = (msg_len(data[7:4]) == 2'd2);
                d1_d    = '0;
                state_d = mask_q[data[3:0]] ? ST_WAIT_D1 : ST_SKIP;
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        if (len2_q) begin
                            d1_d    = data[6:0];
                            state_d = ST_WAIT_D2;
                        end else begin
                            emit    = 1'b1;
                            emit_d1 = data[6:0];
                            state_d = RUNNING_STATUS ? ST_WAIT_D1 : ST_IDLE;
                        end
                    end
                    ST_WAIT_D2: begin
                        emit    = 1'b1;
                        emit_d1 = d1_q;
                        emit_d2 = data[6:0];
                        state_d = RUNNING_STATUS ? ST_WAIT_D1 : ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end

        if (emit) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = chan_q;
            evt_d1_d    = emit_d1;
            evt_d2_d    = emit_d2;
            evt_type_d  = (ZERO_VEL_IS_OFF && kind_q == EVT_NOTE_ON && emit_d2 == 7'd0)
                          ? EVT_NOTE_OFF : kind_q;
        end
    end

    // State, held message and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= EVT_NOTE_OFF;
            chan_q      <= '0;
            len2_q      <= 1'b0;
            d1_q        <= '0;
            mask_q      <= CH_MASK_DEFAULT;
            evt_valid_q <= 1'b0;
            evt_type_q  <= EVT_NOTE_OFF;
            evt_ch_q    <= '0;
            evt_d1_q    <= '0;
            evt_d2_q    <= '0;
            rt_valid_q  <= 1'b0;
            rt_byte_q   <= '0;
            sys_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            chan_q      <= chan_d;
            len2_q      <= len2_d;
            d1_q        <= d1_d;
            mask_q      <= mask_d;
            evt_valid_q <= evt_valid_d;
            evt_type_q  <= evt_type_d;
            evt_ch_q    <= evt_ch_d;
            evt_d1_q    <= evt_d1_d;
            evt_d2_q    <= evt_d2_d;
            rt_valid_q  <= rt_valid_d;
            rt_byte_q   <= rt_byte_d;
            sys_reset_q <= sys_reset_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_type  = evt_type_q;
    assign evt_ch    = evt_ch_q;
    assign evt_d1    = evt_d1_q;
    assign evt_d2    = evt_d2_q;
    assign rt_valid  = rt_valid_q;
    assign rt_byte   = rt_byte_q;
    assign sys_reset = sys_reset_q;
    assign state     = state_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed scenarios plus a random
// byte stream, compared every cycle against a queue-based message model.
module tb_midi_msg_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        dv = 1'b0;
    logic        ch_mask_wr = 1'b0;
    logic [15:0] ch_mask_in = 16'h0000;
    logic        evt_valid;
    logic [2:0]  evt_type;
    logic [3:0]  evt_ch;
    logic [6:0]  evt_d1;
    logic [6:0]  evt_d2;
    logic        rt_valid;
    logic [7:0]  rt_byte;
    logic        sys_reset;
    logic [2:0]  state;

    midi_msg_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .data       (data),
        .dv         (dv),
        .ch_mask_wr (ch_mask_wr),
        .ch_mask_in (ch_mask_in),
        .evt_valid  (evt_valid),
        .evt_type   (evt_type),
        .evt_ch     (evt_ch),
        .evt_d1     (evt_d1),
        .evt_d2     (evt_d2),
        .rt_valid   (rt_valid),
        .rt_byte    (rt_byte),
        .sys_reset  (sys_reset),
        .state      (state)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ev(input logic [2:0] t, input logic [3:0] c,
                                       input logic [6:0] a, input logic [6:0] b);
        return 32'({t, c, a, b});
    endfunction

    // ---------------- behavioural model ----------------
    // Running status is a byte plus a list of data bytes collected so far;
    // a message completes when the list reaches the status's data length.
    bit          m_rs_ok;
    logic [7:0]  m_rs;
    logic [6:0]  m_dq[$];
    logic [2:0]  m_sink;      // reported state when no running status is held
    logic [15:0] m_mask;

    logic        exp_evt_valid, exp_rt_valid, exp_sys_reset;
    logic [2:0]  exp_evt_type, exp_state;
    logic [3:0]  exp_evt_ch;
    logic [6:0]  exp_evt_d1, exp_evt_d2;
    logic [7:0]  exp_rt_byte;

    task automatic model_reset();
        m_rs_ok = 1'b0; m_rs = 8'h00; m_dq.delete(); m_sink = 3'd0; m_mask = 16'h0001;
        exp_evt_valid = 0; exp_rt_valid = 0; exp_sys_reset = 0;
        exp_evt_type = 0; exp_evt_ch = 0; exp_evt_d1 = 0; exp_evt_d2 = 0;
        exp_rt_byte = 0; exp_state = 0;
    endtask

    task automatic model_step();
        logic [15:0] old_mask;
        int          need;
        logic [6:0]  d2;
        logic [2:0]  t;
        exp_evt_valid = 0; exp_rt_valid = 0; exp_sys_reset = 0;
        if (ce) begin
            old_mask = m_mask;
            if (ch_mask_wr) m_mask = ch_mask_in;
            if (dv) begin
                if (data == 8'hFF) begin
                    m_rs_ok = 0; m_dq.delete(); m_sink = 3'd0; exp_sys_reset = 1;
                end else if (data >= 8'hF8) begin
                    exp_rt_valid = 1; exp_rt_byte = data;
                end else if (data >= 8'hF0) begin
                    m_rs_ok = 0; m_dq.delete(); m_sink = (data == 8'hF0) ? 3'd3 : 3'd4;
                end else if (data >= 8'h80) begin
                    m_dq.delete();
                    if (old_mask[data[3:0]]) begin
                        m_rs_ok = 1; m_rs = data;
                    end else begin
                        m_rs_ok = 0; m_sink = 3'd4;
                    end
                end else if (m_rs_ok) begin
                    m_dq.push_back(data[6:0]);
                    need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
                    if (m_dq.size() == need) begin
                        d2 = (need == 2) ? m_dq[1] : 7'd0;
                        t  = 3'(m_rs[7:4] - 4'h8);
                        if (t == 3'd1 && d2 == 7'd0) t = 3'd0;
                        exp_evt_valid = 1; exp_evt_type = t; exp_evt_ch = m_rs[3:0];
                        exp_evt_d1 = m_dq[0]; exp_evt_d2 = d2;
                        m_dq.delete();
                    end
                end
            end
        end
        exp_state = m_rs_ok ? ((m_dq.size() == 0) ? 3'd1 : 3'd2) : m_sink;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- compare process ----------------
    logic [20:0] dut_evts[$];
    logic [7:0]  dut_rts[$];
    int          sysres_cnt = 0;

    always @(negedge clk) begin
        chk("evt_valid", 32'(evt_valid), 32'(exp_evt_valid));
        chk("evt_type",  32'(evt_type),  32'(exp_evt_type));
        chk("evt_ch",    32'(evt_ch),    32'(exp_evt_ch));
        chk("evt_d1",    32'(evt_d1),    32'(exp_evt_d1));
        chk("evt_d2",    32'(evt_d2),    32'(exp_evt_d2));
        chk("rt_valid",  32'(rt_valid),  32'(exp_rt_valid));
        chk("rt_byte",   32'(rt_byte),   32'(exp_rt_byte));
        chk("sys_reset", 32'(sys_reset), 32'(exp_sys_reset));
        chk("state",     32'(state),     32'(exp_state));
        if (evt_valid === 1'b1) dut_evts.push_back({evt_type, evt_ch, evt_d1, evt_d2});
        if (rt_valid === 1'b1)  dut_rts.push_back(rt_byte);
        if (sys_reset === 1'b1) sysres_cnt++;
    end

    function automatic logic [31:0] evt_at(input int i);
        if (i < dut_evts.size()) return 32'(dut_evts[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic [7:0] b, input logic v, input logic c,
                         input logic w, input logic [15:0] m);
        @(posedge clk); #2;
        data = b; dv = v; ce = c; ch_mask_wr = w; ch_mask_in = m;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b, 1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic set_mask(input logic [15:0] m);
        drive(8'h00, 1'b0, 1'b1, 1'b1, m);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        dv = 1'b0; rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sr0;
        int r;
        logic [7:0] b;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_evt_valid", 32'(evt_valid), 32'd0);
        chk("reset_rt_byte", 32'(rt_byte), 32'd0);

        // Basic Note On on channel 0
        dut_evts.delete();
        send(8'h90); send(8'h3C); send(8'h64); idle(3);
        chk("t1_count", 32'(dut_evts.size()), 32'd1);
        chk("t1_evt", evt_at(0), ev(3'd1, 4'd0, 7'h3C, 7'h64));

        // Running status with zero velocity becoming Note Off
        dut_evts.delete();
        send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00); idle(3);
        chk("t2_count", 32'(dut_evts.size()), 32'd2);
        chk("t2_evt0", evt_at(0), ev(3'd1, 4'd0, 7'h3C, 7'h64));
        chk("t2_evt1", evt_at(1), ev(3'd0, 4'd0, 7'h3E, 7'h00));

        // Real-time byte inside a message
        dut_evts.delete(); dut_rts.delete();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(3);
        chk("t3_rt_count", 32'(dut_rts.size()), 32'd1);
        chk("t3_rt_byte", (dut_rts.size() > 0) ? 32'(dut_rts[0]) : 32'hFFFF_FFFF, 32'hF8);
        chk("t3_evt", evt_at(0), ev(3'd1, 4'd0, 7'h3C, 7'h64));

        // Channel mask filtering and a one-byte Program Change
        dut_evts.delete();
        set_mask(16'h0004);
        send(8'h91); send(8'h3C); send(8'h64); send(8'hC2); send(8'h05); idle(3);
        chk("t4_count", 32'(dut_evts.size()), 32'd1);
        chk("t4_evt", evt_at(0), ev(3'd4, 4'd2, 7'h05, 7'h00));

        // SysEx skipped, stray data dropped, then Pitch Bend
        dut_evts.delete();
        set_mask(16'h0001);
        send(8'hF0); send(8'h10); send(8'h20); send(8'hF7); send(8'h40);
        send(8'hE0); send(8'h00); send(8'h40); idle(3);
        chk("t5_count", 32'(dut_evts.size()), 32'd1);
        chk("t5_evt", evt_at(0), ev(3'd6, 4'd0, 7'h00, 7'h40));

        // System reset byte aborts a message
        dut_evts.delete();
        sr0 = sysres_cnt;
        send(8'h90); send(8'h3C); send(8'hFF); send(8'h64); idle(3);
        chk("t6_sysreset", 32'(sysres_cnt - sr0), 32'd1);
        chk("t6_count", 32'(dut_evts.size()), 32'd0);

        // Asynchronous reset mid-message
        dut_evts.delete();
        send(8'h90); send(8'h3C); pulse_reset();
        chk("t7_state", 32'(state), 32'd0);
        chk("t7_evt_d1", 32'(evt_d1), 32'd0);
        chk("t7_evt_type", 32'(evt_type), 32'd0);
        send(8'h64); idle(3);
        chk("t7_count", 32'(dut_evts.size()), 32'd0);

        // Mask write in the same cycle as a status: old mask decides
        dut_evts.delete();
        drive(8'h93, 1'b1, 1'b1, 1'b1, 16'h0008);
        send(8'h3C); send(8'h64);
        send(8'h93); send(8'h3C); send(8'h64); idle(3);
        chk("t8_count", 32'(dut_evts.size()), 32'd1);
        chk("t8_evt", evt_at(0), ev(3'd1, 4'd3, 7'h3C, 7'h64));

        // Status during WAIT_D2 drops the partial message; ce low ignores bytes
        dut_evts.delete();
        set_mask(16'h0001);
        send(8'h90); send(8'h3C); send(8'h80);
        drive(8'h11, 1'b1, 1'b0, 1'b0, 16'h0000);
        send(8'h3C); send(8'h40); idle(3);
        chk("t9_count", 32'(dut_evts.size()), 32'd1);
        chk("t9_evt", evt_at(0), ev(3'd0, 4'd0, 7'h3C, 7'h40));

        // Random stream against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = 8'($urandom_range(0, 127));
            else if (r < 75) b = 8'h80 + 8'($urandom_range(0, 111));
            else if (r < 83) b = 8'hF8 + 8'($urandom_range(0, 6));
            else if (r < 88) b = 8'hF0;
            else if (r < 91) b = 8'hF7;
            else if (r < 94) b = 8'hF1 + 8'($urandom_range(0, 5));
            else if (r < 96) b = 8'hFF;
            else             b = 8'($urandom_range(0, 127));
            drive(b, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 39) == 0), 16'($urandom));
        end
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
Parametrised successor to the single-channel note/program FSM. Parses a serial MIDI byte stream from the UART receiver into complete channel-voice events for all seven message types, for any subset of the 16 channels. Supports running status, interleaved real-time bytes, SysEx skipping and system reset. It sits between the MIDI UART byte output and the voice allocator / program register.

Parameters:
CH_MASK_DEFAULT, 16'h0001, reset value of the internal channel-accept mask (bit n = accept channel n).
RUNNING_STATUS, 1, 1 = data bytes reuse the last channel status; 0 = data bytes without a fresh status are discarded.
ZERO_VEL_IS_OFF, 1, 1 = Note On with velocity 0 is reported as a Note Off event.
RESET_ON_FF, 1, 1 = byte 8'hFF aborts the current message and pulses sys_reset.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; all state and outputs hold when low, except that pulse outputs are cleared
data  in  8  received byte
dv  in  1  data valid; sampled only when ce=1
ch_mask_wr  in  1  load ch_mask_in into the channel mask (ce-gated)
ch_mask_in  in  16  new channel mask
evt_valid  out  1  one-cycle pulse: event fields valid
evt_type  out  3  0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CC, 4 PROG, 5 CH_PRESS, 6 PITCH_BEND
evt_ch  out  4  channel of event
evt_d1  out  7  first data byte (note, controller, program, pressure, bend LSB)
evt_d2  out  7  second data byte (velocity, value, bend MSB); 0 for one-byte messages
rt_valid  out  1  one-cycle pulse on a real-time byte F8–FE
rt_byte  out  8  the real-time byte
sys_reset  out  1  one-cycle pulse on FF when RESET_ON_FF=1
state  out  3  current FSM state (debug)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; running status cleared; mask=CH_MASK_DEFAULT; all outputs 0.
- Byte accepted = ce & dv. Nothing changes on a cycle without an accepted byte, except that pulses return to 0.
- States:
  - IDLE: no valid running status.
  - WAIT_D1: status held, expecting the first data byte.
  - WAIT_D2: first data byte held, expecting the second.
  - SYSEX: inside F0, skipping.
  - SKIP: status not for us, or system-common; discard data bytes.
- Real-time bytes F8–FE, in any state: rt_valid=1 and rt_byte=data on the next cycle. State, status and held data are untouched.
- Byte FF with RESET_ON_FF=1: state=IDLE, running status cleared, sys_reset pulse next cycle. With RESET_ON_FF=0, FF is treated as a real-time byte.
- Channel status 80–EF, in any state:
  - Abort any partial message and store the status.
  - Channel mask bit set: go to WAIT_D1. Otherwise go to SKIP.
  - Data length is 2 for 8x, 9x, Ax, Bx, Ex and 1 for Cx, Dx.
- Byte F0: state=SYSEX; running status cleared.
- Bytes F1–F7 (F7 included): running status cleared; state=SKIP. F7 ends SysEx.
- Data bytes (bit7=0):
  - IDLE/SKIP/SYSEX: discarded.
  - WAIT_D1, length 1: emit the event and stay in WAIT_D1 (running status) if RUNNING_STATUS=1, else go to IDLE.
  - WAIT_D1, length 2: latch d1 and go to WAIT_D2.
  - WAIT_D2: emit the event; go to WAIT_D1 if RUNNING_STATUS=1, else IDLE.
- Event latency: evt_* registered, evt_valid high exactly on the cycle after the final data byte is accepted. evt_* hold their value until the next event.
- ZERO_VEL_IS_OFF=1 and 9x with d2=0: evt_type=NOTE_OFF, evt_d2=0.
- Mask write: takes effect for the next status byte. A mask write does not affect a message already in WAIT_D1/WAIT_D2. If ch_mask_wr and a status byte occur in the same cycle, the old mask decides that byte.
- Status byte arriving in WAIT_D2: the partial message is dropped silently and no event is emitted.
- Illegal state encodings recover to IDLE.

Decomposition:
- Package midi_pkg holds:
  - status nibble constants (8–E, F0, F7, FF)
  - evt_type enumeration
  - state encoding
  - function msg_len(status) returning 1 or 2
- No sub-module: a single FSM plus the output register. An optional midi_rt_filter is not warranted.

Test Plan:
- Mask=0x0001; bytes 90 3C 64 -> one evt_valid, type=1, ch=0, d1=0x3C, d2=0x64, one cycle after the 64.
- 90 3C 64 3E 00 (running status, ZERO_VEL_IS_OFF=1) -> two events: NOTE_ON 3C/64, then NOTE_OFF 3E/00.
- 90 3C F8 64 -> rt_valid with rt_byte=F8 after the F8; NOTE_ON 3C/64 still emitted.
- Mask=0x0004; 91 3C 64 then C2 05 -> no event for ch1; PROG event ch=2, d1=05, d2=0.
- F0 10 20 F7 then 40 then E0 00 40 -> no event for the SysEx or the stray 40; PITCH_BEND ch0 d1=00 d2=40.
- 90 3C, then FF, then 64; also rst_n pulsed low mid-message, then 64 -> sys_reset pulse, no event; after rst_n, outputs are 0 and no event.
